// File: rtl/delay_line_pkg.sv
// -----------------------------------------------------------------------------
// delay_line_pkg
// Shared definitions for the tapped delay-line TDC:
//   - state_t  : measurement FSM states
//   - cw_f()   : width of a tap count able to hold 0..taps
//   - DEF_*    : default parameter values for the TDC and its tap cells
// -----------------------------------------------------------------------------
package delay_line_pkg;
    timeunit 1fs;
    timeprecision 1fs;

    localparam int DEF_TAPS         = 32;
    localparam int DEF_MAX_AVG_LOG2 = 7;
    localparam int DEF_SIM_TAP_FS   = 50000;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        CAPTURE,
        SYNC,
        ACCUM,
        DONE
    } state_t;

    // Bits needed to represent any count from 0 up to and including taps.
    function automatic int cw_f(input int taps);
        return $clog2(taps + 1);
    endfunction

endpackage

// File: rtl/delay_line_tap.sv
// -----------------------------------------------------------------------------
// delay_line_tap
// One non-inverting buffer stage of the TDC delay line.
//   a : stage input (previous tap, or the launch flop for tap 0)
//   y : stage output, a delayed copy of a
// In silicon the stage is a buffer kept intact by the dont_touch attribute on
// its instance; its propagation delay is the TDC's time quantum. In simulation
// the same delay is modelled as SIM_TAP_FS femtoseconds; synthesis ignores the
// delay value on the assignment.
// -----------------------------------------------------------------------------
module delay_line_tap
    import delay_line_pkg::*;
#(
    parameter int SIM_TAP_FS = DEF_SIM_TAP_FS
) (
    input  logic a,
    output logic y
);
    timeunit 1fs;
    timeprecision 1fs;

    assign #(SIM_TAP_FS) y = a;

endmodule

// File: rtl/delay_line_tdc.sv
// -----------------------------------------------------------------------------
// delay_line_tdc
// Tapped delay-line time-to-digital converter. Each sample toggles a launch
// flop into a TAPS-long buffer chain, freezes the chain one clock period later,
// resynchronises it, and counts how many taps the edge travelled through.
// 2^cfg samples are summed and the result is offered on a valid/ready port.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      request a measurement (only honoured while idle)
//   cfg_avg_i    log2 of the sample count, clamped to MAX_AVG_LOG2
//   busy_o       a measurement is in progress or awaiting readout
//   valid_o      result available; held until ready_i
//   ready_i      consumer takes the result
//   mean_o       sum_o >> cfg (average taps per sample)
//   sum_o        raw accumulated tap count
//   sat_o        sticky: a sample saw the edge run off the end of the chain
//   zero_o       sticky: a sample saw the edge reach no tap at all
// -----------------------------------------------------------------------------
module delay_line_tdc
    import delay_line_pkg::*;
#(
    parameter  int TAPS         = DEF_TAPS,
    parameter  int MAX_AVG_LOG2 = DEF_MAX_AVG_LOG2,
    parameter  int SIM_TAP_FS   = DEF_SIM_TAP_FS,
    localparam int CW           = cw_f(TAPS),
    localparam int AW           = $clog2(MAX_AVG_LOG2 + 1),
    localparam int SW           = CW + MAX_AVG_LOG2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [AW-1:0] cfg_avg_i,
    output logic          busy_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [CW-1:0] mean_o,
    output logic [SW-1:0] sum_o,
    output logic          sat_o,
    output logic          zero_o
);
    timeunit 1fs;
    timeprecision 1fs;

    state_t                  state;
    state_t                  state_next;

    logic                    launch_q;
    logic [TAPS:0]           chain;
    logic [TAPS-1:0]         tap;
    logic [TAPS-1:0]         cap_q;
    logic [TAPS-1:0]         sync_q;

    logic [AW-1:0]           cfg_q;
    logic [AW-1:0]           cfg_clamped;
    logic [MAX_AVG_LOG2-1:0] cnt_q;
    logic [SW-1:0]           sum_q;
    logic                    sat_q;
    logic                    zero_q;

    logic [CW-1:0]           count;
    logic                    last_sample;

    // ------------------------------------------------------------------
    // Delay line: chain[0] is the launch flop, chain[i+1] is tap i.
    // ------------------------------------------------------------------
    assign chain[0] = launch_q;

    for (genvar i = 0; i < TAPS; i++) begin : g_tap
        (* dont_touch = "true" *)
        delay_line_tap #(
            .SIM_TAP_FS(SIM_TAP_FS)
        ) u_tap (
            .a(chain[i]),
            .y(chain[i+1])
        );
    end

    assign tap = chain[TAPS:1];

    // ------------------------------------------------------------------
    // Configuration and sample bookkeeping
    // ------------------------------------------------------------------
    // Compared as 32-bit so the clamp stays meaningful when AW can encode
    // values above MAX_AVG_LOG2.
    assign cfg_clamped = (32'(cfg_avg_i) > MAX_AVG_LOG2) ? AW'(MAX_AVG_LOG2) : cfg_avg_i;

    assign last_sample = (32'(cnt_q) == ((32'd1 << cfg_q) - 32'd1));

    // Taps that now agree with the launch level are the ones the edge
    // reached. A population count rather than a priority encoder keeps
    // thermometer bubbles from producing large errors.
    always_comb begin
        count = '0;
        for (int i = 0; i < TAPS; i++) begin
            count = count + CW'(sync_q[i] ^ ~launch_q);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks, so every flop
        // samples the values that existed before the edge.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first, so no path through the case leaves
        // state_next unassigned and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = LAUNCH;
            LAUNCH:  state_next = CAPTURE;
            CAPTURE: state_next = SYNC;
            SYNC:    state_next = ACCUM;
            ACCUM:   state_next = last_sample ? DONE : LAUNCH;
            DONE:    if (ready_i) state_next = IDLE;   // valid_o is high throughout DONE
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy_o  = 1'b0;
        valid_o = 1'b0;
        if (state != IDLE) busy_o  = 1'b1;
        if (state == DONE) valid_o = 1'b1;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the capture and sync registers are ordinary flops, not
            // a memory, so they are cleared along with the rest of the state.
            launch_q <= 1'b0;
            cap_q    <= '0;
            sync_q   <= '0;
            cfg_q    <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            sat_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        cfg_q  <= cfg_clamped;
                        cnt_q  <= '0;
                        sum_q  <= '0;
                        sat_q  <= 1'b0;
                        zero_q <= 1'b0;
                    end
                end
                // Polarity is never reset between samples or measurements,
                // so consecutive samples alternate rising and falling edges.
                LAUNCH:  launch_q <= ~launch_q;
                // Exactly one period after the launch edge.
                CAPTURE: cap_q <= tap;
                // Second stage gives a metastable capture bit a full period
                // to resolve before it reaches the counter.
                SYNC:    sync_q <= cap_q;
                ACCUM: begin
                    sum_q <= sum_q + SW'(count);
                    if (count == CW'(TAPS)) sat_q  <= 1'b1;
                    if (count == '0)        zero_q <= 1'b1;
                    if (!last_sample)       cnt_q  <= cnt_q + MAX_AVG_LOG2'(1);
                end
                default: ;
            endcase
        end
    end

    // The sum of 2^cfg counts each <= TAPS shifted back down always fits CW.
    assign sum_o  = sum_q;
    assign mean_o = CW'(sum_q >> cfg_q);
    assign sat_o  = sat_q;
    assign zero_o = zero_q;

endmodule

// File: tb/tb_delay_line_tdc.sv
// -----------------------------------------------------------------------------
// tb_delay_line_tdc
// Three TDC instances share one clock and reset and differ only in tap delay:
//   unit 0 : 45 ps/tap  -> the edge passes 22 taps per period
//   unit 1 : 30 ps/tap  -> the edge runs off the 32-tap chain
//   unit 2 : 2 ns/tap   -> the edge reaches no tap within a period
// The reference model works from measurement-level rules: a start accepted
// while idle produces a result 4*2^cfg edges later whose sum is 2^cfg times
// the taps an edge covers in one period; the result is held until ready.
// -----------------------------------------------------------------------------
module tb_delay_line_tdc;
    timeunit 1fs;
    timeprecision 1fs;

    localparam int TAPS      = 32;
    localparam int MAXL      = 7;
    localparam int CW        = $clog2(TAPS + 1);
    localparam int SW        = CW + MAXL;
    localparam int AW        = $clog2(MAXL + 1);
    localparam int PERIOD_FS = 1000000;
    localparam int NU        = 3;
    localparam int TAP_A     = 45000;
    localparam int TAP_B     = 30000;
    localparam int TAP_C     = 2000000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start [NU];
    logic [AW-1:0] cfg   [NU];
    logic          ready [NU];
    logic          busy  [NU];
    logic          valid [NU];
    logic [CW-1:0] mean  [NU];
    logic [SW-1:0] sum   [NU];
    logic          sat   [NU];
    logic          zero  [NU];

    int n_cmp  = 0;
    int n_fail = 0;

    always #(PERIOD_FS / 2) clk = ~clk;

    delay_line_tdc #(.TAPS(TAPS), .MAX_AVG_LOG2(MAXL), .SIM_TAP_FS(TAP_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .cfg_avg_i(cfg[0]),
        .busy_o(busy[0]), .valid_o(valid[0]), .ready_i(ready[0]),
        .mean_o(mean[0]), .sum_o(sum[0]), .sat_o(sat[0]), .zero_o(zero[0])
    );

    delay_line_tdc #(.TAPS(TAPS), .MAX_AVG_LOG2(MAXL), .SIM_TAP_FS(TAP_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .cfg_avg_i(cfg[1]),
        .busy_o(busy[1]), .valid_o(valid[1]), .ready_i(ready[1]),
        .mean_o(mean[1]), .sum_o(sum[1]), .sat_o(sat[1]), .zero_o(zero[1])
    );

    delay_line_tdc #(.TAPS(TAPS), .MAX_AVG_LOG2(MAXL), .SIM_TAP_FS(TAP_C)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start_i(start[2]), .cfg_avg_i(cfg[2]),
        .busy_o(busy[2]), .valid_o(valid[2]), .ready_i(ready[2]),
        .mean_o(mean[2]), .sum_o(sum[2]), .sat_o(sat[2]), .zero_o(zero[2])
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference
    // ------------------------------------------------------------------
    function automatic int tap_fs(input int u);
        case (u)
            0:       return TAP_A;
            1:       return TAP_B;
            default: return TAP_C;
        endcase
    endfunction

    // Tap i has switched by the capture edge when (i+1)*delay < period.
    function automatic int exp_count(input int u);
        int n;
        n = (PERIOD_FS - 1) / tap_fs(u);
        return (n > TAPS) ? TAPS : n;
    endfunction

    function automatic int clamp_cfg(input int c);
        return (c > MAXL) ? MAXL : c;
    endfunction

    bit m_busy  [NU];
    bit m_valid [NU];
    int m_left  [NU];
    int m_n     [NU];

    always @(posedge clk or negedge rst_n) begin
        for (int u = 0; u < NU; u++) begin
            if (!rst_n) begin
                m_busy[u]  <= 1'b0;
                m_valid[u] <= 1'b0;
                m_left[u]  <= 0;
            end else if (!m_busy[u]) begin
                if (start[u]) begin
                    m_busy[u] <= 1'b1;
                    m_n[u]    <= 1 << clamp_cfg(int'(cfg[u]));
                    m_left[u] <= 4 * (1 << clamp_cfg(int'(cfg[u]))) - 1;
                end
            end else if (m_valid[u]) begin
                if (ready[u]) begin
                    m_busy[u]  <= 1'b0;
                    m_valid[u] <= 1'b0;
                end
            end else if (m_left[u] == 0) begin
                m_valid[u] <= 1'b1;
            end else begin
                m_left[u] <= m_left[u] - 1;
            end
        end
    end

    // Compare on the falling edge, half a period clear of any DUT update.
    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            check($sformatf("u%0d_busy", u), busy[u], m_busy[u]);
            check($sformatf("u%0d_valid", u), valid[u], m_valid[u]);
            if (m_valid[u]) begin
                check($sformatf("u%0d_sum", u), sum[u], m_n[u] * exp_count(u));
                check($sformatf("u%0d_mean", u), mean[u], exp_count(u));
                check($sformatf("u%0d_sat", u), sat[u], exp_count(u) == TAPS);
                check($sformatf("u%0d_zero", u), zero[u], exp_count(u) == 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called on a falling edge)
    // ------------------------------------------------------------------
    task automatic start_meas(input int u, input int c);
        cfg[u]   = AW'(c);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
    endtask

    // Returns the number of rising edges after the accepting one until
    // valid is seen; an expired budget shows up as a failed comparison.
    task automatic wait_valid(input int u, input string name, output int edges);
        edges = 0;
        while (valid[u] !== 1'b1 && edges < 2000) begin
            @(negedge clk);
            edges++;
        end
        check({name, "_valid_seen"}, valid[u], 1);
    endtask

    task automatic ack(input int u);
        ready[u] = 1'b1;
        @(negedge clk);
        ready[u] = 1'b0;
    endtask

    task automatic check_result(input string name, input int u, input int e_sum,
                                input int e_mean, input int e_sat, input int e_zero);
        check({name, "_sum"},  sum[u],  e_sum);
        check({name, "_mean"}, mean[u], e_mean);
        check({name, "_sat"},  sat[u],  e_sat);
        check({name, "_zero"}, zero[u], e_zero);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios followed by randomised traffic
    // ------------------------------------------------------------------
    initial begin
        int e;
        int r;

        rst_n = 1'b0;
        for (int u = 0; u < NU; u++) begin
            start[u] = 1'b0;
            ready[u] = 1'b0;
            cfg[u]   = '0;
        end

        // Long reset also lets the slow chain settle from power-up.
        repeat (100) @(negedge clk);
        check("reset_busy", busy[0], 0);
        check("reset_valid", valid[0], 0);
        check_result("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Edge runs off the chain: every sample counts all 32 taps.
        start_meas(1, 1);
        wait_valid(1, "t3", e);
        check("t3_latency", e, 8);
        check_result("t3", 1, 64, 32, 1, 0);
        ack(1);

        // Edge reaches no tap: rising launch, then falling after settling.
        start_meas(2, 0);
        wait_valid(2, "t4a", e);
        check("t4a_latency", e, 4);
        check_result("t4a", 2, 0, 0, 0, 1);
        ack(2);
        repeat (80) @(negedge clk);
        start_meas(2, 0);
        wait_valid(2, "t4b", e);
        check_result("t4b", 2, 0, 0, 0, 1);
        ack(2);

        // Four samples of 22 taps; valid raised by the 16th edge after accept.
        start_meas(0, 2);
        wait_valid(0, "t1", e);
        check("t1_latency", e, 16);
        check_result("t1", 0, 88, 22, 0, 0);
        ack(0);

        // Back-to-back single samples: rising launch then falling launch.
        start_meas(0, 0);
        wait_valid(0, "t2_rise", e);
        check_result("t2_rise", 0, 22, 22, 0, 0);
        ack(0);
        start_meas(0, 0);
        wait_valid(0, "t2_fall", e);
        check_result("t2_fall", 0, 22, 22, 0, 0);
        ack(0);

        // Backpressure: result held, start ignored in DONE, even with ready.
        start_meas(0, 1);
        wait_valid(0, "t5", e);
        for (int i = 0; i < 10; i++) begin
            start[0] = (i == 3);
            @(negedge clk);
            check("t5_hold_valid", valid[0], 1);
            check("t5_hold_busy", busy[0], 1);
            check("t5_hold_sum", sum[0], 44);
            check("t5_hold_mean", mean[0], 22);
        end
        start[0] = 1'b1;
        ready[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        ready[0] = 1'b0;
        check("t5_busy_after_ack", busy[0], 0);
        check("t5_valid_after_ack", valid[0], 0);
        @(negedge clk);
        check("t5_no_restart", busy[0], 0);

        // Reset asserted between clock edges during the third sample.
        start_meas(0, 3);
        repeat (9) @(negedge clk);
        check("t6_busy_before", busy[0], 1);
        #(PERIOD_FS / 8);
        rst_n = 1'b0;
        #1000;
        check("t6_async_busy", busy[0], 0);
        check("t6_async_valid", valid[0], 0);
        check_result("t6_async", 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_meas(0, 0);
        wait_valid(0, "t6_after", e);
        check_result("t6_after", 0, 22, 22, 0, 0);
        ack(0);

        // Random traffic on unit 0: starts at any time, random readiness.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start[0] = ($urandom_range(0, 4) == 0);
            r        = int'($urandom_range(0, 15));
            cfg[0]   = (r == 15) ? AW'(7) : AW'(r % 4);
            ready[0] = ($urandom_range(0, 2) != 0);
        end
        start[0] = 1'b0;
        ready[0] = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
